// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
//   Shared definitions for the program-sequencing unit: default widths,
//   opcode constants, the decoded-operation enum and the opcode decoder.
//   Optional feature macro used by the slice: PC_SEQ_RET_STACK_EN.
// -----------------------------------------------------------------------------
package pc_seq_pkg;

    // Default widths
    localparam int OPC_W_DEF       = 4;
    localparam int IMM_W_DEF       = 4;
    localparam int DBUS_W_DEF      = 8;
    localparam int STACK_DEPTH_DEF = 4;

    // Branch opcodes (all other opcodes are sequential)
    localparam logic [3:0] OP_JMP  = 4'hF;
    localparam logic [3:0] OP_JNC  = 4'hE;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hB;

    typedef enum logic [2:0] {
        OPK_NONE = 3'd0,
        OPK_JMP  = 3'd1,
        OPK_JNC  = 3'd2,
        OPK_JC   = 3'd3,
        OPK_CALL = 3'd4,
        OPK_RET  = 3'd5
    } op_e;

    // Opcode arrives zero-extended to 8 bits so wider opcode fields never
    // alias onto the branch codes.
    function automatic op_e decode_op(input logic [7:0] opc);
        op_e kind;
        case (opc)
            {4'h0, OP_JMP}:  kind = OPK_JMP;
            {4'h0, OP_JNC}:  kind = OPK_JNC;
            {4'h0, OP_JC}:   kind = OPK_JC;
            {4'h0, OP_CALL}: kind = OPK_CALL;
            {4'h0, OP_RET}:  kind = OPK_RET;
            default:         kind = OPK_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/pc_seq_ret_stack.sv
// -----------------------------------------------------------------------------
// pc_ret_stack
//   DEPTH x W hardware return stack (LIFO) built as a circular buffer.
//   A push on a full stack overwrites the oldest entry and sets err; a pop on
//   an empty stack leaves the stack unchanged and sets err. err is sticky
//   until reset.
// Ports
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   push, pop     one-cycle strobes (never both high)
//   wdata         value pushed
//   rdata         current top of stack (valid when !empty)
//   empty, full   occupancy flags
//   err           sticky over/underflow flag
// -----------------------------------------------------------------------------
module pc_ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full,
    output logic         err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_r [DEPTH];
    logic [IDX_W-1:0] wr_idx_r;   // next free slot; wraps, so a full push lands on the oldest entry
    logic [IDX_W-1:0] top_idx_s;
    logic [CNT_W-1:0] cnt_r;      // occupancy 0..DEPTH
    logic             err_r;

    assign top_idx_s = wr_idx_r - IDX_W'(1);
    assign rdata     = mem_r[top_idx_s];
    assign empty     = (cnt_r == CNT_W'(0));
    assign full      = (cnt_r == CNT_W'(DEPTH));
    assign err       = err_r;

    // Pointer, occupancy and sticky error state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_idx_r <= IDX_W'(0);
            cnt_r    <= CNT_W'(0);
            err_r    <= 1'b0;
        end else if (push) begin
            wr_idx_r <= wr_idx_r + IDX_W'(1);
            if (full) begin
                err_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                err_r <= 1'b1;
            end else begin
                wr_idx_r <= top_idx_s;
                cnt_r    <= cnt_r - CNT_W'(1);
            end
        end else begin
            wr_idx_r <= wr_idx_r;
        end
    end

    // Storage array; contents are don't-care after reset
    always_ff @(posedge clock) begin
        if (push) begin
            mem_r[wr_idx_r] <= wdata;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// -----------------------------------------------------------------------------
// pc_seq
//   Program-sequencing unit: holds the fetch PC, decodes the execute-stage
//   opcode, resolves JMP/JNC/JC/CALL/RET and flags a fetch flush on every
//   taken redirect.
//   Optional feature: define PC_SEQ_RET_STACK_EN to build the hardware return
//   stack. Without it CALL acts as JMP, RET is sequential and stack_err is 0.
// Ports
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   instr_valid      instruction_out holds a real instruction
//   instruction_out  {opcode, immediate}
//   D_BUS            low target bits
//   cflag            ALU carry flag
//   stall            hold PC/stack, suppress redirects
//   address          registered PC
//   flush            combinational: discard the fetched instruction
//   stack_err        sticky return-stack over/underflow
// -----------------------------------------------------------------------------
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int OPC_W       = OPC_W_DEF,
    parameter int IMM_W       = IMM_W_DEF,
    parameter int DBUS_W      = DBUS_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      instr_valid,
    input  logic [OPC_W+IMM_W-1:0]    instruction_out,
    input  logic [DBUS_W-1:0]         D_BUS,
    input  logic                      cflag,
    input  logic                      stall,
    output logic [IMM_W+DBUS_W-1:0]   address,
    output logic                      flush,
    output logic                      stack_err
);

    localparam int ADDR_W = IMM_W + DBUS_W;
    localparam int INST_W = OPC_W + IMM_W;

    if ((STACK_DEPTH < 2) || ((STACK_DEPTH & (STACK_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("pc_seq: STACK_DEPTH must be a power of two >= 2");
    end

    logic [OPC_W-1:0]  opc_s;
    op_e               op_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] seq_s;
    logic [ADDR_W-1:0] next_s;
    logic              taken_s;
    logic              valid_s;
    logic [ADDR_W-1:0] address_r;

    assign opc_s    = instruction_out[INST_W-1 -: OPC_W];
    assign op_s     = decode_op(8'(opc_s));
    assign target_s = {instruction_out[IMM_W-1:0], D_BUS};
    assign seq_s    = address_r + ADDR_W'(1);
    assign valid_s  = instr_valid & ~stall;

`ifdef PC_SEQ_RET_STACK_EN
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] rdata_s;
    logic              empty_s;
    logic              full_s;
    logic              err_s;

    // RET with an empty stack still strobes pop so the stack records the underflow
    assign push_s = valid_s & (op_s == OPK_CALL);
    assign pop_s  = valid_s & (op_s == OPK_RET);

    pc_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (seq_s),
        .rdata (rdata_s),
        .empty (empty_s),
        .full  (full_s),
        .err   (err_s)
    );

    assign stack_err = err_s;
`else
    assign stack_err = 1'b0;
`endif

    // Next-PC selection and taken decision
    always_comb begin
        next_s  = seq_s;
        taken_s = 1'b0;
        if (valid_s) begin
            case (op_s)
                OPK_JMP: begin
                    next_s  = target_s;
                    taken_s = 1'b1;
                end
                OPK_JNC: begin
                    if (cflag == 1'b0) begin
                        next_s  = target_s;
                        taken_s = 1'b1;
                    end else begin
                        next_s  = seq_s;
                        taken_s = 1'b0;
                    end
                end
                OPK_JC: begin
                    if (cflag == 1'b1) begin
                        next_s  = target_s;
                        taken_s = 1'b1;
                    end else begin
                        next_s  = seq_s;
                        taken_s = 1'b0;
                    end
                end
                OPK_CALL: begin
                    next_s  = target_s;
                    taken_s = 1'b1;
                end
`ifdef PC_SEQ_RET_STACK_EN
                OPK_RET: begin
                    if (!empty_s) begin
                        next_s  = rdata_s;
                        taken_s = 1'b1;
                    end else begin
                        next_s  = seq_s;
                        taken_s = 1'b0;
                    end
                end
`endif
                default: begin
                    next_s  = seq_s;
                    taken_s = 1'b0;
                end
            endcase
        end else begin
            next_s  = seq_s;
            taken_s = 1'b0;
        end
    end

    // Flush is masked during reset so a pending redirect is dropped cleanly
    assign flush = valid_s & taken_s & ~reset;

    // PC register; stall freezes it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            address_r <= ADDR_W'(0);
        end else if (!stall) begin
            address_r <= next_s;
        end else begin
            address_r <= address_r;
        end
    end

    assign address = address_r;

endmodule

// File: tb/tb_pc_seq.sv
// -----------------------------------------------------------------------------
// tb_pc_seq
//   Directed self-checking bench for pc_seq. Inputs change on the falling
//   edge; flush is sampled 1 ns after the inputs, address 1 ns after the
//   rising edge. Stack scenarios run when PC_SEQ_RET_STACK_EN is defined,
//   the stackless CALL/RET scenario otherwise.
// -----------------------------------------------------------------------------
module tb_pc_seq;

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic [7:0]  instruction_out;
    logic [7:0]  D_BUS;
    logic        cflag;
    logic        stall;
    logic [11:0] address;
    logic        flush;
    logic        stack_err;

    int total = 0;
    int bad   = 0;

    pc_seq dut (
        .clock           (clock),
        .reset           (reset),
        .instr_valid     (instr_valid),
        .instruction_out (instruction_out),
        .D_BUS           (D_BUS),
        .cflag           (cflag),
        .stall           (stall),
        .address         (address),
        .flush           (flush),
        .stack_err       (stack_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] imm, input logic [7:0] d,
                         input logic v, input logic c, input logic s);
        @(negedge clock);
        instruction_out = {op, imm};
        D_BUS           = d;
        instr_valid     = v;
        cflag           = c;
        stall           = s;
    endtask

    // One instruction: check flush in the same cycle, address after the edge
    task automatic step(input string tag, input logic [3:0] op, input logic [3:0] imm,
                        input logic [7:0] d, input logic v, input logic c, input logic s,
                        input logic exp_flush, input logic [11:0] exp_addr);
        drive(op, imm, d, v, c, s);
        #1;
        chk({tag, "_flush"}, 32'(flush), 32'(exp_flush));
        @(posedge clock);
        #1;
        chk({tag, "_addr"}, 32'(address), 32'(exp_addr));
    endtask

    initial begin
        reset           = 1'b1;
        instr_valid     = 1'b0;
        instruction_out = 8'h00;
        D_BUS           = 8'h00;
        cflag           = 1'b0;
        stall           = 1'b0;
        #12;
        chk("rst_addr", 32'(address), 32'h000);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_err", 32'(stack_err), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Reach 0x345, then reset asynchronously mid-cycle with a JMP pending
        step("jmp345", 4'hF, 4'h3, 8'h45, 1'b1, 1'b0, 1'b0, 1'b1, 12'h345);
        drive(4'hF, 4'hF, 8'hFF, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_addr", 32'(address), 32'h000);
        chk("midrst_flush", 32'(flush), 32'h0);
        chk("midrst_err", 32'(stack_err), 32'h0);
        @(posedge clock);
        #1;
        chk("midrst_hold", 32'(address), 32'h000);
        @(negedge clock);
        reset = 1'b0;

        step("jmpA5C",   4'hF, 4'hA, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b1, 12'hA5C);
        step("jmpstall", 4'hF, 4'h1, 8'h23, 1'b1, 1'b0, 1'b1, 1'b0, 12'hA5C);
        step("jncstall", 4'hE, 4'h1, 8'h23, 1'b1, 1'b0, 1'b1, 1'b0, 12'hA5C);
        step("jnc_c1",   4'hE, 4'h7, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 12'hA5D);
        step("jc_c1",    4'hD, 4'h0, 8'h12, 1'b1, 1'b1, 1'b0, 1'b1, 12'h012);
        step("jnc_c0",   4'hE, 4'h0, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h0F0);
        step("jc_c0",    4'hD, 4'h8, 8'h88, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0F1);
        step("jmpFFF",   4'hF, 4'hF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 12'hFFF);
        step("nopwrap",  4'h0, 4'h5, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
        step("bubble",   4'hF, 4'h7, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 12'h001);
        step("nop_a",    4'h3, 4'h9, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 12'h002);

`ifdef PC_SEQ_RET_STACK_EN
        step("to100",    4'hF, 4'h1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 12'h100);
        step("call200",  4'hC, 4'h2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 12'h200);
        step("ret101",   4'hB, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 12'h101);
        chk("err_after_ret", 32'(stack_err), 32'h0);
        // Return addresses pushed: 0x102, 0x111, 0x121, 0x131, 0x141
        step("call1",    4'hC, 4'h1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 12'h110);
        step("call2",    4'hC, 4'h1, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1, 12'h120);
        step("call3",    4'hC, 4'h1, 8'h30, 1'b1, 1'b0, 1'b0, 1'b1, 12'h130);
        step("call4",    4'hC, 4'h1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b1, 12'h140);
        chk("err_full", 32'(stack_err), 32'h0);
        step("call5",    4'hC, 4'h1, 8'h50, 1'b1, 1'b0, 1'b0, 1'b1, 12'h150);
        chk("err_ovf", 32'(stack_err), 32'h1);
        step("retstall", 4'hB, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 12'h150);
        step("ret1",     4'hB, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 12'h141);
        step("ret2",     4'hB, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 12'h131);
        step("ret3",     4'hB, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 12'h121);
        step("ret4",     4'hB, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 12'h111);
        step("ret5",     4'hB, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'h112);
        chk("err_sticky", 32'(stack_err), 32'h1);
`else
        step("call300",  4'hC, 4'h3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 12'h300);
        step("retseq",   4'hB, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'h301);
        step("retseq2",  4'hB, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'h302);
        chk("err_none", 32'(stack_err), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
